// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared state type and sizes for the truth-table scanner
package scan_pkg;

    localparam int N_COMB = 8;
    localparam int IDX_W  = 3;
    localparam int TT_W   = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } scan_state_t;

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - parameterized-depth flop chain, depth 0 is a wire
module sync_ff #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic w_unused;
            assign w_unused = clk ^ rst_n;
            assign q        = d;
        end else begin : g_chain
            logic [DEPTH-1:0] r_chain;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_chain <= '0;
                end else begin
                    r_chain[0] <= d;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_chain[i] <= r_chain[i-1];
                    end
                end
            end

            assign q = r_chain[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/truth_table_scanner.sv
// rtl/truth_table_scanner.sv - walks a 3-input logic module through all 8 inputs
// and assembles its truth-table code, MSB = input 000.
module truth_table_scanner
    import scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [TT_W-1:0] expected,
    output logic            in1,
    output logic            in2,
    output logic            in3,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic [TT_W-1:0] table_out,
    output logic            match
);

    localparam logic [7:0]       CNT_RELOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_COMB - 1);

    scan_state_t      r_state;
    scan_state_t      w_state_next;
    logic [IDX_W-1:0] r_idx;
    logic [7:0]       r_cnt;
    logic [TT_W-1:0]  r_shadow;
    logic [TT_W-1:0]  r_expected;
    logic [TT_W-1:0]  r_table;
    logic             r_match;

    logic             w_dut_sync;
    logic             w_accept;
    logic             w_sample;
    logic             w_last;
    logic [IDX_W-1:0] w_bit_pos;
    logic [IDX_W-1:0] w_stim;
    logic [TT_W-1:0]  w_shadow_next;

    sync_ff #(
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (dut_out),
        .q     (w_dut_sync)
    );

    // abort outranks both a new start and a pending sample
    assign w_accept  = (r_state == IDLE) && start && !abort;
    assign w_sample  = (r_state == SETTLE) && !abort && (r_cnt == 8'd0);
    assign w_last    = w_sample && (r_idx == LAST_IDX);
    assign w_bit_pos = LAST_IDX - r_idx;

    always_comb begin
        w_shadow_next            = r_shadow;
        w_shadow_next[w_bit_pos] = w_dut_sync;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (abort) begin
                    w_state_next = IDLE;
                end else if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        w_stim = '0;
        case (r_state)
            SETTLE: begin
                busy   = 1'b1;
                w_stim = r_idx;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign in1 = w_stim[2];
    assign in2 = w_stim[1];
    assign in3 = w_stim[0];

    // table_out/match only move on the final sample, so an abort leaves the last result visible
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_cnt      <= '0;
            r_shadow   <= '0;
            r_expected <= '0;
            r_table    <= '0;
            r_match    <= 1'b0;
        end else if (w_accept) begin
            r_expected <= expected;
            r_shadow   <= '0;
            r_idx      <= '0;
            r_cnt      <= CNT_RELOAD;
        end else if (r_state == SETTLE) begin
            if (abort) begin
                r_idx <= '0;
            end else if (r_cnt != 8'd0) begin
                r_cnt <= r_cnt - 8'd1;
            end else begin
                r_shadow <= w_shadow_next;
                if (r_idx != LAST_IDX) begin
                    r_idx <= r_idx + IDX_W'(1);
                    r_cnt <= CNT_RELOAD;
                end else begin
                    r_table <= w_shadow_next;
                    r_match <= (w_shadow_next == r_expected);
                end
            end
        end
    end

    assign table_out = r_table;
    assign match     = r_match;

endmodule

// File: tb/tb_truth_table_scanner.sv
// tb/tb_truth_table_scanner.sv - self-checking bench, two scanner configurations
module tb_truth_table_scanner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_v    [2];
    logic       abort_v    [2];
    logic [7:0] expected_v [2];
    logic       in1_v      [2];
    logic       in2_v      [2];
    logic       in3_v      [2];
    logic       dut_out_v  [2];
    logic       busy_v     [2];
    logic       done_v     [2];
    logic [7:0] table_v    [2];
    logic       match_v    [2];

    logic [7:0] fn_v       [2];
    logic [7:0] prev_table [2];
    logic       prev_match [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    truth_table_scanner #(.SETTLE_CYCLES(4), .SYNC_STAGES(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]),
        .expected(expected_v[0]), .in1(in1_v[0]), .in2(in2_v[0]), .in3(in3_v[0]),
        .dut_out(dut_out_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .table_out(table_v[0]), .match(match_v[0])
    );

    truth_table_scanner #(.SETTLE_CYCLES(1), .SYNC_STAGES(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]),
        .expected(expected_v[1]), .in1(in1_v[1]), .in2(in2_v[1]), .in3(in3_v[1]),
        .dut_out(dut_out_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .table_out(table_v[1]), .match(match_v[1])
    );

    // Logic module under test: output for input k is bit (7-k) of its truth-table code
    always_comb begin
        for (int d = 0; d < 2; d++) begin
            dut_out_v[d] = fn_v[d][3'd7 - {in1_v[d], in2_v[d], in3_v[d]}];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] stim(input int d);
        return {29'd0, in1_v[d], in2_v[d], in3_v[d]};
    endfunction

    // Called and returns at a negedge. abort_at / rst_at / restart_at are cycle offsets after T0, -1 = unused.
    task automatic run_scan(input int d, input int s, input logic [7:0] fn, input logic [7:0] expv,
                            input int abort_at, input int rst_at, input int restart_at);
        int pulses;
        fn_v[d]       = fn;
        expected_v[d] = expv;
        start_v[d]    = 1'b1;
        @(negedge clk);
        start_v[d]    = 1'b0;
        expected_v[d] = ~expv;
        for (int c = 0; c < 8 * s; c++) begin
            check("busy_scan", busy_v[d], 1);
            check("done_scan", done_v[d], 0);
            check("stim_seq", stim(d), c / s);
            if (c == abort_at) begin
                abort_v[d] = 1'b1;
                @(negedge clk);
                abort_v[d] = 1'b0;
                check("abort_busy", busy_v[d], 0);
                check("abort_stim", stim(d), 0);
                check("abort_table", table_v[d], prev_table[d]);
                check("abort_match", match_v[d], prev_match[d]);
                pulses = 0;
                for (int j = 0; j < 8 * s + 2; j++) begin
                    pulses += int'(done_v[d]) + int'(busy_v[d]);
                    @(negedge clk);
                end
                check("abort_no_done", pulses, 0);
                return;
            end
            if (c == rst_at) begin
                rst_n = 1'b0;
                #1;
                for (int e = 0; e < 2; e++) begin
                    check("rst_busy", busy_v[e], 0);
                    check("rst_done", done_v[e], 0);
                    check("rst_table", table_v[e], 0);
                    check("rst_match", match_v[e], 0);
                    check("rst_stim", stim(e), 0);
                    prev_table[e] = 8'h00;
                    prev_match[e] = 1'b0;
                end
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                return;
            end
            start_v[d] = (c == restart_at);
            @(negedge clk);
            start_v[d] = 1'b0;
        end
        check("done_pulse", done_v[d], 1);
        check("done_busy", busy_v[d], 0);
        check("done_stim", stim(d), 0);
        check("table_out", table_v[d], fn);
        check("match", match_v[d], fn == expv);
        prev_table[d] = fn;
        prev_match[d] = (fn == expv);
        pulses = 0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            pulses += int'(done_v[d]) + int'(busy_v[d]);
        end
        check("done_single", pulses, 0);
        check("table_hold", table_v[d], fn);
    endtask

    initial begin
        int d;
        int s;
        logic [7:0] fn;
        logic [7:0] ex;
        int ab;
        int rs;

        rst_n = 1'b0;
        for (int e = 0; e < 2; e++) begin
            start_v[e] = 1'b0; abort_v[e] = 1'b0; expected_v[e] = 8'h00;
            fn_v[e] = 8'h00; prev_table[e] = 8'h00; prev_match[e] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int e = 0; e < 2; e++) begin
            check("reset_busy", busy_v[e], 0);
            check("reset_done", done_v[e], 0);
            check("reset_table", table_v[e], 0);
            check("reset_match", match_v[e], 0);
            check("reset_stim", stim(e), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        run_scan(0, 4, 8'h40, 8'h40, -1, -1, -1);
        run_scan(0, 4, 8'h69, 8'h40, -1, -1, -1);
        run_scan(1, 1, 8'hFF, 8'hFF, -1, -1, -1);

        run_scan(0, 4, 8'h40, 8'h40, -1, -1, -1);
        run_scan(0, 4, 8'h69, 8'h69, 13, -1, -1);

        run_scan(0, 4, 8'h69, 8'h69, -1, 22, -1);
        run_scan(0, 4, 8'h40, 8'h40, -1, -1, -1);

        run_scan(0, 4, 8'h40, 8'h40, -1, -1, 10);

        // start together with abort in IDLE: the start is dropped
        start_v[0] = 1'b1; abort_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0; abort_v[0] = 1'b0;
        check("idle_start_abort_busy", busy_v[0], 0);
        abort_v[0] = 1'b1;
        @(negedge clk);
        abort_v[0] = 1'b0;
        check("idle_abort_busy", busy_v[0], 0);
        check("idle_abort_table", table_v[0], prev_table[0]);

        for (int i = 0; i < 16; i++) begin
            d  = i % 2;
            s  = (d == 0) ? 4 : 1;
            fn = 8'($urandom);
            ex = ($urandom_range(0, 1) == 1) ? fn : 8'($urandom);
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8 * s - 1)) : -1;
            rs = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 8 * s - 1)) : -1;
            run_scan(d, s, fn, ex, ab, -1, rs);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
